// File: rtl/pipe_issue_ctrl.sv
// In-order issue and hazard controller for the 5-stage ADD/SUB pipeline.
// A shift-register scoreboard tracks in-flight destinations; sources that match any entry stall.
module pipe_issue_ctrl #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [4:0]       in_rd,
  input  logic             flush,
  output logic             issue_valid,
  output logic [1:0]       issue_op,
  output logic [4:0]       issue_rs1,
  output logic [4:0]       issue_rs2,
  output logic [4:0]       issue_rd,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             r_sb_v  [DEPTH];
  logic [4:0]       r_sb_rd [DEPTH];
  logic             r_issue_valid;
  logic [1:0]       r_issue_op;
  logic [4:0]       r_issue_rs1;
  logic [4:0]       r_issue_rs2;
  logic [4:0]       r_issue_rd;
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_hazard;
  logic w_busy;
  logic w_ready;
  logic w_accept;
  logic w_stall;

  // The oldest entry still hazards: its write only lands at the coming edge.
  always_comb begin
    w_hazard = 1'b0;
    w_busy   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_busy = w_busy | r_sb_v[i];
      if (r_sb_v[i] && ((r_sb_rd[i] == in_rs1) || (r_sb_rd[i] == in_rs2)))
        w_hazard = 1'b1;
    end
  end

  assign w_ready  = ~w_hazard & ~flush;
  assign w_accept = in_valid & w_ready;
  assign w_stall  = in_valid & ~w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_sb_v[i]  <= 1'b0;
        r_sb_rd[i] <= '0;
      end
      r_issue_valid <= 1'b0;
      r_issue_op    <= '0;
      r_issue_rs1   <= '0;
      r_issue_rs2   <= '0;
      r_issue_rd    <= '0;
      r_issue_cnt   <= '0;
      r_stall_cnt   <= '0;
    end else begin
      // w_accept is already low during flush, so sb[0] needs no extra squash.
      r_sb_v[0]  <= w_accept;
      r_sb_rd[0] <= in_rd;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        r_sb_v[i]  <= r_sb_v[i-1] & ~flush;
        r_sb_rd[i] <= r_sb_rd[i-1];
      end
      r_issue_valid <= w_accept;
      if (w_accept) begin
        r_issue_op  <= in_op;
        r_issue_rs1 <= in_rs1;
        r_issue_rs2 <= in_rs2;
        r_issue_rd  <= in_rd;
      end
      if (w_accept && (r_issue_cnt != '1))
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready    = w_ready;
  assign busy        = w_busy;
  assign wb_valid    = r_sb_v[DEPTH-1];
  assign wb_rd       = r_sb_rd[DEPTH-1];
  assign issue_valid = r_issue_valid;
  assign issue_op    = r_issue_op;
  assign issue_rs1   = r_issue_rs1;
  assign issue_rs2   = r_issue_rs2;
  assign issue_rd    = r_issue_rd;
  assign issue_cnt   = r_issue_cnt;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: directed scenarios plus random traffic against a
// timestamped in-flight-write model; a CNT_W=4 copy shares the inputs to exercise saturation.
module tb_pipe_issue_ctrl;

  localparam int DEPTH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_op = '0;
  logic [4:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic       flush = 1'b0;

  logic        in_ready, issue_valid, wb_valid, busy;
  logic [1:0]  issue_op;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic [15:0] issue_cnt, stall_cnt;

  logic        s_in_ready, s_issue_valid, s_wb_valid, s_busy;
  logic [1:0]  s_issue_op;
  logic [4:0]  s_issue_rs1, s_issue_rs2, s_issue_rd, s_wb_rd;
  logic [3:0]  s_issue_cnt, s_stall_cnt;

  pipe_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_rd(issue_rd), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .busy(busy), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  pipe_issue_ctrl #(.DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush),
    .issue_valid(s_issue_valid), .issue_op(s_issue_op), .issue_rs1(s_issue_rs1),
    .issue_rs2(s_issue_rs2), .issue_rd(s_issue_rd), .wb_valid(s_wb_valid), .wb_rd(s_wb_rd),
    .busy(s_busy), .issue_cnt(s_issue_cnt), .stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted write is kept with its accept-edge number until it commits.
  typedef struct { logic [4:0] rd; int t; } wr_t;
  wr_t q[$];
  int  now;
  int  m_icnt, m_scnt;
  logic       m_iv;
  logic [1:0] m_op;
  logic [4:0] m_rs1, m_rs2, m_rd;

  task automatic model_reset();
    q.delete();
    now = 0; m_icnt = 0; m_scnt = 0;
    m_iv = 0; m_op = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
  endtask

  function automatic logic model_ready();
    logic haz = 1'b0;
    foreach (q[k]) if (q[k].rd == in_rs1 || q[k].rd == in_rs2) haz = 1'b1;
    return !haz && !flush;
  endfunction

  task automatic check_outputs();
    logic exp_wb = 1'b0;
    logic [4:0] exp_wbrd = '0;
    logic rdy = model_ready();
    foreach (q[k]) if (now - q[k].t == DEPTH - 1) begin exp_wb = 1'b1; exp_wbrd = q[k].rd; end
    check("in_ready", in_ready, rdy);
    check("in_ready4", s_in_ready, rdy);
    check("busy", busy, q.size() > 0);
    check("wb_valid", wb_valid, exp_wb);
    if (exp_wb) check("wb_rd", wb_rd, exp_wbrd);
    check("issue_valid", issue_valid, m_iv);
    check("issue_op", issue_op, m_op);
    check("issue_rs1", issue_rs1, m_rs1);
    check("issue_rs2", issue_rs2, m_rs2);
    check("issue_rd", issue_rd, m_rd);
    check("issue_cnt", issue_cnt, (m_icnt > 65535) ? 65535 : m_icnt);
    check("stall_cnt", stall_cnt, (m_scnt > 65535) ? 65535 : m_scnt);
    check("issue_cnt4", s_issue_cnt, (m_icnt > 15) ? 15 : m_icnt);
    check("stall_cnt4", s_stall_cnt, (m_scnt > 15) ? 15 : m_scnt);
  endtask

  // Called at posedge+1 with inputs set; checks mid-cycle, advances one edge, returns at posedge+1.
  task automatic cycle(output logic acc);
    logic rdy;
    wr_t  keep[$];
    #2;
    check_outputs();
    rdy = model_ready();
    acc = in_valid & rdy;
    @(posedge clk);
    now++;
    if (flush) q.delete();
    else if (acc) q.push_back('{rd: in_rd, t: now});
    foreach (q[k]) if (now - q[k].t < DEPTH) keep.push_back(q[k]);
    q = keep;
    m_iv = acc;
    if (acc) begin m_op = in_op; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rd = in_rd; end
    if (acc) m_icnt++;
    if (in_valid && !rdy) m_scnt++;
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    in_valid = 0; flush = 0;
    for (int k = 0; k < n; k++) cycle(a);
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    logic acc = 1'b0;
    in_valid = 1; flush = 0; in_op = op; in_rs1 = a; in_rs2 = b; in_rd = d;
    for (int k = 0; k < 20 && !acc; k++) cycle(acc);
    check("send_accepted", acc, 1);
    in_valid = 0;
  endtask

  task automatic do_reset();
    #1 rst = 1;
    #1;
    check("rst_wb_valid", wb_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_in_ready", in_ready, 1);
    model_reset();
    @(posedge clk); #1 rst = 0;
  endtask

  int s0;
  logic acc;
  logic pending;

  initial begin
    model_reset();
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_wb_valid", wb_valid, 0);
    @(posedge clk); #1 rst = 0;
    idle(2);

    // Four independent ADDs back to back.
    for (int k = 1; k <= 4; k++) send(2'b00, 5'd10, 5'd11, 5'(k));
    idle(5);
    check("four_add_issue_cnt", issue_cnt, 4);
    check("four_add_stall_cnt", stall_cnt, 0);

    // d=1 dependency: three stall cycles.
    s0 = m_scnt;
    send(2'b00, 5'd10, 5'd11, 5'd1);
    send(2'b01, 5'd1, 5'd2, 5'd5);
    check("d1_stalls", stall_cnt, s0 + 3);
    idle(4);

    // d=2 dependency via rs2: two stall cycles.
    s0 = m_scnt;
    send(2'b00, 5'd10, 5'd11, 5'd7);
    send(2'b10, 5'd12, 5'd13, 5'd8);
    send(2'b01, 5'd14, 5'd7, 5'd9);
    check("d2_stalls", stall_cnt, s0 + 2);
    idle(4);

    // Flush with three writes in flight and a held dependent instruction.
    send(2'b00, 5'd10, 5'd11, 5'd1);
    send(2'b00, 5'd10, 5'd11, 5'd2);
    send(2'b00, 5'd10, 5'd11, 5'd3);
    in_valid = 1; in_op = 2'b01; in_rs1 = 5'd3; in_rs2 = 5'd1; in_rd = 5'd6; flush = 1;
    cycle(acc);
    check("flush_no_accept", acc, 0);
    flush = 0;
    cycle(acc);
    check("after_flush_accept", acc, 1);
    idle(4);

    // Asynchronous reset while a write is due.
    send(2'b00, 5'd10, 5'd11, 5'd1);
    send(2'b00, 5'd10, 5'd11, 5'd2);
    send(2'b00, 5'd10, 5'd11, 5'd3);
    check("pre_rst_wb_valid", wb_valid, 1);
    do_reset();
    idle(1);

    // Long stall held by flush: narrow counter saturates at 15.
    in_valid = 1; in_op = 2'b00; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3; flush = 1;
    for (int k = 0; k < 20; k++) cycle(acc);
    flush = 0; in_valid = 0;
    check("stall_sat4", s_stall_cnt, 15);
    check("stall_wide", stall_cnt, 20);
    idle(2);

    // Random traffic; fields held stable while stalled.
    pending = 0;
    for (int k = 0; k < 400; k++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        in_rs1   = 5'($urandom_range(0, 7));
        in_rs2   = 5'($urandom_range(0, 7));
        in_rd    = 5'($urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 19) == 0);
      cycle(acc);
      pending = in_valid && !acc;
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
